// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit.
// Holds the opcode constants, the FSM state encoding, the ALU operation
// encoding, and the select encodings for the datapath muxes. It also holds
// small helpers for branch resolution.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        S_RESET,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_EXEC_U,
        S_ALUWB,
        S_BRANCH,
        S_JALR_ADR,
        S_JUMP,
        S_TRAP
    } state_e;

    // ADD is zero so that an idle or reset controller drives alu_control = 0.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_ctrl_e;

    // Operation class handed from the FSM to the ALU decoder.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'd0,
        ALUOP_SUB   = 2'd1,
        ALUOP_FUNCT = 2'd2
    } alu_op_e;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    // funct3 010 and 011 are unassigned in the BRANCH major opcode.
    function automatic logic branch_legal(input logic [2:0] funct3);
        return funct3[2:1] != 2'b01;
    endfunction

    function automatic logic branch_taken(input logic [2:0] funct3,
                                          input logic zero,
                                          input logic lt,
                                          input logic ltu);
        logic taken;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = lt;
            3'b101:  taken = !lt;
            3'b110:  taken = ltu;
            3'b111:  taken = !ltu;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder.
// Maps the FSM's operation class plus funct3/funct7_5 to an ALU operation.
//   alu_op      : operation class (ADD, SUB, or decode from funct fields)
//   funct3      : IR[14:12]
//   funct7_5    : IR[30]
//   op_5        : opcode bit 5, set for register-register OP, clear for OP-IMM
//   alu_control : ALU operation encoding
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       op_5,
    output logic [3:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // IR[30] selects SUB only for OP; for ADDI it is immediate data.
                    3'b000:  alu_control = (op_5 && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_control = ALU_SLL;
                    3'b010:  alu_control = ALU_SLT;
                    3'b011:  alu_control = ALU_SLTU;
                    3'b100:  alu_control = ALU_XOR;
                    // SRA/SRAI share IR[30] as the arithmetic-shift flag.
                    3'b101:  alu_control = funct7_5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control unit.
// The unit sequences fetch, decode, execute, memory and writeback over one
// shared memory port. The state is registered. The datapath controls are
// combinational from the state and the current inputs.
//   clk, rst_n          : clock, asynchronous active-low reset
//   op, funct3, funct7_5: instruction fields from IR
//   zero, lt, ltu       : ALU compare flags for branch resolution
//   mem_ready           : memory completes the current access this cycle
//   mem_req, mem_write, adr_src            : memory interface control
//   ir_write, pc_write, reg_write          : state-element write enables
//   result_src, alu_src_a, alu_src_b,
//   imm_src, alu_control                   : datapath mux / ALU selects
//   instr_done          : one-cycle retire pulse
//   trap                : illegal instruction
//   retired_count       : retired instruction count (wraps)
module multicycle_control_unit
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned ALU_CTRL_W = 4,
    parameter int unsigned CNT_W      = 32,
    parameter bit          TRAP_HALT  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            op,
    input  logic [2:0]            funct3,
    input  logic                  funct7_5,
    input  logic                  zero,
    input  logic                  lt,
    input  logic                  ltu,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  mem_write,
    output logic                  adr_src,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  reg_write,
    output logic [1:0]            result_src,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [2:0]            imm_src,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  instr_done,
    output logic                  trap,
    output logic [CNT_W-1:0]      retired_count
);

    state_e     state;
    state_e     next_state;
    alu_op_e    alu_op;
    logic [3:0] dec_control;

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7_5    (funct7_5),
        .op_5        (op[5]),
        .alu_control (dec_control)
    );

    assign alu_control = ALU_CTRL_W'(dec_control);

    always_comb begin
        next_state = state;
        case (state)
            S_RESET:    next_state = S_FETCH;
            S_FETCH:    if (mem_ready) next_state = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: next_state = S_MEMADR;
                    OP_OP:             next_state = S_EXEC_R;
                    OP_OPIMM:          next_state = S_EXEC_I;
                    OP_BRANCH:         next_state = S_BRANCH;
                    OP_JAL:            next_state = S_JUMP;
                    OP_JALR:           next_state = S_JALR_ADR;
                    OP_LUI, OP_AUIPC:  next_state = S_EXEC_U;
                    default:           next_state = S_TRAP;
                endcase
            end
            S_MEMADR:   next_state = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) next_state = S_MEMWB;
            S_MEMWB:    next_state = S_FETCH;
            S_MEMWRITE: if (mem_ready) next_state = S_FETCH;
            S_EXEC_R,
            S_EXEC_I,
            S_EXEC_U:   next_state = S_ALUWB;
            S_ALUWB:    next_state = S_FETCH;
            S_BRANCH:   next_state = branch_legal(funct3) ? S_FETCH : S_TRAP;
            S_JALR_ADR: next_state = S_JUMP;
            S_JUMP:     next_state = S_ALUWB;
            S_TRAP:     next_state = TRAP_HALT ? S_TRAP : S_FETCH;
            default:    next_state = S_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_RESET;
            retired_count <= '0;
        end else begin
            state <= next_state;
            if (instr_done) retired_count <= retired_count + CNT_W'(1);
        end
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        imm_src    = IMM_I;
        alu_op     = ALUOP_ADD;
        instr_done = 1'b0;
        trap       = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_a  = SRCA_PC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            S_DECODE: begin
                // Speculative OldPC + imm gives the branch/JAL target in ALUOut.
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (op)
                    OP_STORE:         imm_src = IMM_S;
                    OP_BRANCH:        imm_src = IMM_B;
                    OP_LUI, OP_AUIPC: imm_src = IMM_U;
                    OP_JAL:           imm_src = IMM_J;
                    default:          imm_src = IMM_I;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                imm_src   = op[5] ? IMM_S : IMM_I;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src = RES_RDATA;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req    = 1'b1;
                mem_write  = 1'b1;
                adr_src    = 1'b1;
                instr_done = mem_ready;
            end
            S_EXEC_R: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALUOP_FUNCT;
            end
            S_EXEC_I: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_I;
                alu_op    = ALUOP_FUNCT;
            end
            S_EXEC_U: begin
                alu_src_a = (op == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_U;
            end
            S_ALUWB: begin
                result_src = RES_ALUOUT;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                alu_op     = ALUOP_SUB;
                result_src = RES_ALUOUT;
                if (branch_legal(funct3)) begin
                    pc_write   = branch_taken(funct3, zero, lt, ltu);
                    instr_done = 1'b1;
                end
            end
            S_JALR_ADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_I;
            end
            S_JUMP: begin
                // PC takes the target held in ALUOut; the link value OldPC+4 replaces it.
                pc_write   = 1'b1;
                result_src = RES_ALUOUT;
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
            end
            S_TRAP: trap = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7_5, zero, lt, ltu, mem_ready;

    logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0]  result_src, alu_src_a, alu_src_b;
    logic [2:0]  imm_src;
    logic [3:0]  alu_control;
    logic        instr_done, trap;
    logic [31:0] retired_count;

    logic        mem_req4, mem_write4, adr_src4, ir_write4, pc_write4, reg_write4;
    logic [1:0]  result_src4, alu_src_a4, alu_src_b4;
    logic [2:0]  imm_src4;
    logic [3:0]  alu_control4;
    logic        instr_done4, trap4;
    logic [3:0]  retired_count4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multicycle_control_unit #(.ALU_CTRL_W(4), .CNT_W(32), .TRAP_HALT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7_5(funct7_5),
        .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .imm_src(imm_src), .alu_control(alu_control), .instr_done(instr_done),
        .trap(trap), .retired_count(retired_count)
    );

    multicycle_control_unit #(.ALU_CTRL_W(4), .CNT_W(4), .TRAP_HALT(1'b0)) dut4 (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7_5(funct7_5),
        .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
        .mem_req(mem_req4), .mem_write(mem_write4), .adr_src(adr_src4),
        .ir_write(ir_write4), .pc_write(pc_write4), .reg_write(reg_write4),
        .result_src(result_src4), .alu_src_a(alu_src_a4), .alu_src_b(alu_src_b4),
        .imm_src(imm_src4), .alu_control(alu_control4), .instr_done(instr_done4),
        .trap(trap4), .retired_count(retired_count4)
    );

    // {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
    //  result_src, alu_src_a, alu_src_b, imm_src, instr_done, trap}
    logic [16:0] ctl;
    assign ctl = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                  result_src, alu_src_a, alu_src_b, imm_src, instr_done, trap};

    localparam logic [16:0] V_IDLE    = 17'b0;
    localparam logic [16:0] V_FETCH   = 17'b1_0_0_1_1_0_10_00_10_000_0_0;
    localparam logic [16:0] V_FETCH_W = 17'b1_0_0_0_0_0_10_00_10_000_0_0;
    localparam logic [16:0] V_DEC_I   = 17'b0_0_0_0_0_0_00_01_01_000_0_0;
    localparam logic [16:0] V_DEC_S   = 17'b0_0_0_0_0_0_00_01_01_001_0_0;
    localparam logic [16:0] V_DEC_B   = 17'b0_0_0_0_0_0_00_01_01_010_0_0;
    localparam logic [16:0] V_DEC_U   = 17'b0_0_0_0_0_0_00_01_01_011_0_0;
    localparam logic [16:0] V_ADR_I   = 17'b0_0_0_0_0_0_00_10_01_000_0_0;
    localparam logic [16:0] V_ADR_S   = 17'b0_0_0_0_0_0_00_10_01_001_0_0;
    localparam logic [16:0] V_MEMRD   = 17'b1_0_1_0_0_0_00_00_00_000_0_0;
    localparam logic [16:0] V_MEMWB   = 17'b0_0_0_0_0_1_01_00_00_000_1_0;
    localparam logic [16:0] V_MEMWR   = 17'b1_1_1_0_0_0_00_00_00_000_1_0;
    localparam logic [16:0] V_EXR     = 17'b0_0_0_0_0_0_00_10_00_000_0_0;
    localparam logic [16:0] V_EXU_LUI = 17'b0_0_0_0_0_0_00_11_01_011_0_0;
    localparam logic [16:0] V_EXU_AUI = 17'b0_0_0_0_0_0_00_01_01_011_0_0;
    localparam logic [16:0] V_ALUWB   = 17'b0_0_0_0_0_1_00_00_00_000_1_0;
    localparam logic [16:0] V_BR_NT   = 17'b0_0_0_0_0_0_00_10_00_000_1_0;
    localparam logic [16:0] V_BR_T    = 17'b0_0_0_0_1_0_00_10_00_000_1_0;
    localparam logic [16:0] V_BR_BAD  = 17'b0_0_0_0_0_0_00_10_00_000_0_0;
    localparam logic [16:0] V_JUMP    = 17'b0_0_0_0_1_0_00_01_10_000_0_0;
    localparam logic [16:0] V_TRAP    = 17'b0_0_0_0_0_0_00_00_00_000_0_1;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUTs in FETCH, 1 time unit after the clock edge.
    task automatic do_reset();
        rst_n = 1'b0;
        op = 7'd0; funct3 = 3'd0; funct7_5 = 1'b0;
        zero = 1'b0; lt = 1'b0; ltu = 1'b0; mem_ready = 1'b1;
        #1;
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        op = 7'b0110011; funct3 = 3'b101; funct7_5 = 1'b1;
        zero = 1'b1; lt = 1'b1; ltu = 1'b1; mem_ready = 1'b1;
        #2;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (ctl !== V_IDLE || alu_control !== 4'd0 || retired_count !== 32'd0) begin
                bad++;
                $display("FAIL reset[%0d]: ctl=%b alu=%0d cnt=%0d, want ctl=%b alu=0 cnt=0",
                         i, ctl, alu_control, retired_count, V_IDLE);
            end
            cyc();
        end
    endtask

    task automatic test_add();
        logic [16:0] exp [4] = '{V_FETCH, V_DEC_I, V_EXR, V_ALUWB};
        do_reset();
        op = 7'b0110011; funct3 = 3'b000; funct7_5 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (ctl !== exp[i]) begin
                bad++;
                $display("FAIL add cycle %0d: ctl=%b want %b", i, ctl, exp[i]);
            end
            if (i == 2) begin
                total++;
                if (alu_control !== 4'd0) begin
                    bad++;
                    $display("FAIL add alu_control: got %0d want 0", alu_control);
                end
            end
            if (i == 3) begin
                total++;
                if (retired_count !== 32'd0) begin
                    bad++;
                    $display("FAIL add count before retire: got %0d want 0", retired_count);
                end
            end
            cyc();
        end
        total++;
        if (retired_count !== 32'd1) begin
            bad++;
            $display("FAIL add count after retire: got %0d want 1", retired_count);
        end
    endtask

    task automatic test_load_wait();
        logic [16:0] exp [8] = '{V_FETCH, V_DEC_I, V_ADR_I, V_MEMRD, V_MEMRD, V_MEMRD, V_MEMRD, V_MEMWB};
        logic        rdy [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        op = 7'b0000011; funct3 = 3'b010;
        for (int i = 0; i < 8; i++) begin
            mem_ready = rdy[i];
            #1;
            total++;
            if (ctl !== exp[i]) begin
                bad++;
                $display("FAIL lw cycle %0d: ctl=%b want %b", i, ctl, exp[i]);
            end
            cyc();
        end
        total++;
        if (retired_count !== 32'd1) begin
            bad++;
            $display("FAIL lw count: got %0d want 1", retired_count);
        end
    endtask

    task automatic test_store();
        logic [16:0] exp [4] = '{V_FETCH, V_DEC_S, V_ADR_S, V_MEMWR};
        do_reset();
        op = 7'b0100011; funct3 = 3'b010;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (ctl !== exp[i]) begin
                bad++;
                $display("FAIL sw cycle %0d: ctl=%b want %b", i, ctl, exp[i]);
            end
            cyc();
        end
        total++;
        if (retired_count !== 32'd1) begin
            bad++;
            $display("FAIL sw count: got %0d want 1", retired_count);
        end
    endtask

    task automatic test_branch();
        logic [2:0]  f3  [7] = '{3'b001, 3'b001, 3'b110, 3'b101, 3'b000, 3'b111, 3'b100};
        logic        z   [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic        l   [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic        lu  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [16:0] exp [7] = '{V_BR_NT, V_BR_T, V_BR_T, V_BR_NT, V_BR_T, V_BR_T, V_BR_NT};
        do_reset();
        op = 7'b1100011;
        for (int i = 0; i < 7; i++) begin
            funct3 = f3[i]; zero = z[i]; lt = l[i]; ltu = lu[i];
            cyc();
            #1;
            total++;
            if (ctl !== V_DEC_B) begin
                bad++;
                $display("FAIL branch %0d decode: ctl=%b want %b", i, ctl, V_DEC_B);
            end
            cyc();
            #1;
            total++;
            if (ctl !== exp[i] || alu_control !== 4'd1) begin
                bad++;
                $display("FAIL branch %0d exec: ctl=%b alu=%0d want ctl=%b alu=1",
                         i, ctl, alu_control, exp[i]);
            end
            cyc();
        end
        total++;
        if (retired_count !== 32'd7) begin
            bad++;
            $display("FAIL branch count: got %0d want 7", retired_count);
        end
        funct3 = 3'b010; zero = 1'b1; lt = 1'b1; ltu = 1'b1;
        repeat (2) cyc();
        #1;
        total++;
        if (ctl !== V_BR_BAD) begin
            bad++;
            $display("FAIL branch illegal funct3: ctl=%b want %b", ctl, V_BR_BAD);
        end
        cyc();
        total++;
        if (ctl !== V_TRAP || retired_count !== 32'd7) begin
            bad++;
            $display("FAIL branch illegal trap: ctl=%b cnt=%0d want ctl=%b cnt=7",
                     ctl, retired_count, V_TRAP);
        end
    endtask

    task automatic test_jalr();
        logic [16:0] exp [5] = '{V_FETCH, V_DEC_I, V_ADR_I, V_JUMP, V_ALUWB};
        do_reset();
        op = 7'b1100111; funct3 = 3'b000;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if (ctl !== exp[i]) begin
                bad++;
                $display("FAIL jalr cycle %0d: ctl=%b want %b", i, ctl, exp[i]);
            end
            cyc();
        end
        total++;
        if (retired_count !== 32'd1) begin
            bad++;
            $display("FAIL jalr count: got %0d want 1", retired_count);
        end
    endtask

    task automatic test_upper();
        logic [6:0]  ops [2] = '{7'b0110111, 7'b0010111};
        logic [16:0] exu [2] = '{V_EXU_LUI, V_EXU_AUI};
        do_reset();
        for (int i = 0; i < 2; i++) begin
            op = ops[i];
            cyc();
            #1;
            total++;
            if (ctl !== V_DEC_U) begin
                bad++;
                $display("FAIL upper %0d decode: ctl=%b want %b", i, ctl, V_DEC_U);
            end
            cyc();
            total++;
            if (ctl !== exu[i] || alu_control !== 4'd0) begin
                bad++;
                $display("FAIL upper %0d exec: ctl=%b alu=%0d want ctl=%b alu=0",
                         i, ctl, alu_control, exu[i]);
            end
            repeat (2) cyc();
        end
        total++;
        if (retired_count !== 32'd2) begin
            bad++;
            $display("FAIL upper count: got %0d want 2", retired_count);
        end
    endtask

    task automatic test_alu_decode();
        logic [6:0] ops [10] = '{7'b0110011, 7'b0010011, 7'b0010011, 7'b0010011, 7'b0110011,
                                 7'b0110011, 7'b0010011, 7'b0110011, 7'b0110011, 7'b0110011};
        logic [2:0] f3  [10] = '{3'b000, 3'b000, 3'b101, 3'b101, 3'b111,
                                 3'b011, 3'b010, 3'b001, 3'b100, 3'b110};
        logic       f7  [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [3:0] exp [10] = '{4'd1, 4'd0, 4'd7, 4'd6, 4'd2, 4'd9, 4'd8, 4'd5, 4'd4, 4'd3};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            op = ops[i]; funct3 = f3[i]; funct7_5 = f7[i];
            repeat (2) cyc();
            #1;
            total++;
            if (alu_control !== exp[i]) begin
                bad++;
                $display("FAIL alu decode %0d (op=%b f3=%b f7_5=%b): got %0d want %0d",
                         i, ops[i], f3[i], f7[i], alu_control, exp[i]);
            end
            repeat (2) cyc();
        end
        total++;
        if (retired_count !== 32'd10) begin
            bad++;
            $display("FAIL alu decode count: got %0d want 10", retired_count);
        end
    endtask

    task automatic test_trap();
        do_reset();
        op = 7'b0110011; funct3 = 3'b000; funct7_5 = 1'b0;
        repeat (4) cyc();
        op = 7'b1111111;
        repeat (2) cyc();
        total++;
        if (trap4 !== 1'b1 || mem_req4 !== 1'b0) begin
            bad++;
            $display("FAIL trap pulse entry: trap=%b mem_req=%b want 1 0", trap4, mem_req4);
        end
        for (int i = 0; i < 12; i++) begin
            total++;
            if (ctl !== V_TRAP || retired_count !== 32'd1) begin
                bad++;
                $display("FAIL trap hold %0d: ctl=%b cnt=%0d want ctl=%b cnt=1",
                         i, ctl, retired_count, V_TRAP);
            end
            if (i == 1) begin
                total++;
                if (trap4 !== 1'b0 || mem_req4 !== 1'b1 || instr_done4 !== 1'b0 ||
                    retired_count4 !== 4'd1) begin
                    bad++;
                    $display("FAIL trap pulse exit: trap=%b mem_req=%b done=%b cnt=%0d want 0 1 0 1",
                             trap4, mem_req4, instr_done4, retired_count4);
                end
            end
            cyc();
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (ctl !== V_IDLE || alu_control !== 4'd0 || retired_count !== 32'd0) begin
            bad++;
            $display("FAIL trap async reset: ctl=%b alu=%0d cnt=%0d want all 0",
                     ctl, alu_control, retired_count);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        op = 7'b0010011; funct3 = 3'b000; funct7_5 = 1'b0;
        for (int n = 1; n <= 17; n++) begin
            repeat (4) cyc();
            if (n == 15 || n == 16 || n == 17) begin
                total++;
                if (retired_count4 !== 4'(n) || retired_count !== 32'(n)) begin
                    bad++;
                    $display("FAIL wrap after %0d: cnt4=%0d cnt32=%0d want %0d %0d",
                             n, retired_count4, retired_count, n % 16, n);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_add();
        test_load_wait();
        test_store();
        test_branch();
        test_jalr();
        test_upper();
        test_alu_decode();
        test_trap();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
